// File: rtl/mem_responder_4port_32b_if.sv
// Bundle of the four CGRA memory-port handshakes into the responder.
//   req[N]      : port N request valid, held until ack[N]
//   write_rq[N] : port N 1 = write, 0 = read
//   addr[N]     : port N word address
//   to_mem[N]   : port N write data
//   from_mem[N] : port N read data, updated only by reads granted to port N
//   ack[N]      : port N one-cycle completion pulse
// master = the CGRA port side, slave = the responder.
`timescale 1ns/1ps
interface mem_responder_4port_32b_if #(
    parameter int WIDTH = 32
);
    logic [3:0]            req;
    logic [3:0]            write_rq;
    logic [3:0][WIDTH-1:0] addr;
    logic [3:0][WIDTH-1:0] to_mem;
    logic [3:0][WIDTH-1:0] from_mem;
    logic [3:0]            ack;

    modport master (
        output req, write_rq, addr, to_mem,
        input  from_mem, ack
    );

    modport slave (
        input  req, write_rq, addr, to_mem,
        output from_mem, ack
    );
endinterface

// File: rtl/mem_responder_4port_32b.sv
// Four-port memory responder: single-ported DEPTH x WIDTH word scratchpad,
// round-robin arbitration over four ports, one access per cycle, registered
// ack pulse and read data.
//   clk   : datapath clock, rising edge
//   rst_n : synchronous active-low reset (acks, read data, pointer)
//   bus   : slave side of the four port handshakes
`timescale 1ns/1ps
module mem_responder_4port_32b #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mem_responder_4port_32b_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);

    // Scratchpad contents are intentionally not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]            ptr_q, ptr_d;
    logic [3:0]            ack_q, ack_d;
    logic [3:0][WIDTH-1:0] from_mem_q, from_mem_d;

    logic [3:0]    eligible;
    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic [AW-1:0] mem_idx;

    // Upper address bits are ignored (addresses wrap modulo DEPTH).
    logic addr_unused;
    assign addr_unused = ^bus.addr;

    // Arbitration: a port acked this cycle is masked so a held request is
    // not served twice. Scan from the farthest offset down so the port
    // closest to ptr wins.
    always_comb begin
        eligible = bus.req & ~ack_q;
        gnt_vld  = 1'b0;
        gnt_idx  = ptr_q;
        cand     = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        mem_idx = bus.addr[gnt_idx][AW-1:0];
    end

    always_comb begin
        ptr_d      = ptr_q;
        ack_d      = '0;
        from_mem_d = from_mem_q;
        if (gnt_vld) begin
            ack_d[gnt_idx] = 1'b1;
            ptr_d          = gnt_idx + 2'd1;
            if (!bus.write_rq[gnt_idx])
                from_mem_d[gnt_idx] = mem[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            ack_q      <= '0;
            from_mem_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            from_mem_q <= from_mem_d;
        end
    end

    // A write granted at the reset edge must not commit.
    always_ff @(posedge clk) begin
        if (rst_n && gnt_vld && bus.write_rq[gnt_idx])
            mem[mem_idx] <= bus.to_mem[gnt_idx];
    end

    assign bus.ack      = ack_q;
    assign bus.from_mem = from_mem_q;
endmodule
